// File: rtl/demux_logic_pipe_if.sv
// Handshake and result bus for demux_logic_pipe.
// master drives operands and consumer ready; slave is the pipeline.
interface demux_logic_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [CH_W-1:0]  ch_sel;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_op;
    logic [N_CH-1:0]  out_valid;
    logic [N_CH-1:0]  out_ready;
    logic             err_pulse;

    modport master (
        output in_valid, a, b, op, ch_sel, out_ready,
        input  in_ready, out_data, out_op, out_valid, err_pulse
    );

    modport slave (
        input  in_valid, a, b, op, ch_sel, out_ready,
        output in_ready, out_data, out_op, out_valid, err_pulse
    );
endinterface

// File: rtl/demux_logic_pipe.sv
// Two-stage bitwise logic unit built from 1:2 demux cells, steering results to N_CH channels.
// Optional per-channel drain counters on port chan_count when DLP_CHAN_COUNT_EN is defined.
module demux_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_logic_pipe_if.slave    bus
`ifdef DLP_CHAN_COUNT_EN
    ,
    output logic [N_CH*16-1:0]   chan_count
`endif
);
    localparam int CH_W = $clog2(N_CH);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_op;
    logic [CH_W-1:0]  s1_ch;

    logic             s2_valid;
    logic             drain;
    logic             s2_adv;
    logic             s1_adv;
    logic             s1_bad;
    logic             accept;
    logic [WIDTH-1:0] result;
    logic [N_CH-1:0]  s1_onehot;

    function automatic logic [1:0] dmx(input logic sel, input logic d);
        return sel ? {d, 1'b0} : {1'b0, d};
    endfunction

    // Each result bit picks one of four demux-derived forms; p = dmx(a,b), q = dmx(b,a).
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [1:0] p;
        logic [1:0] q;
        logic       or_bit;
        assign p      = dmx(s1_a[i], s1_b[i]);
        assign q      = dmx(s1_b[i], s1_a[i]);
        assign or_bit = s1_a[i] | p[0];
        assign result[i] = s1_op[1] ? (s1_op[0] ? ~or_bit : (p[0] | q[0]))
                                    : (s1_op[0] ? or_bit  : p[1]);
    end

    always_comb begin
        s1_onehot = '0;
        for (int k = 0; k < N_CH; k++) begin
            s1_onehot[k] = (s1_ch == CH_W'(k));
        end
    end

    // A bad channel can leave S1 without an S2 slot, so it never waits on backpressure.
    assign s1_bad      = ({{(32-CH_W){1'b0}}, s1_ch} >= 32'(N_CH));
    assign s2_valid    = |bus.out_valid;
    assign drain       = |(bus.out_valid & bus.out_ready);
    assign s2_adv      = !s2_valid || drain;
    assign s1_adv      = s1_valid && (s2_adv || s1_bad);
    assign bus.in_ready = rst_n && (!s1_valid || s1_adv);
    assign accept      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s1_ch    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_op    <= bus.op;
            s1_ch    <= bus.ch_sel;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= '0;
            bus.out_data  <= '0;
            bus.out_op    <= '0;
            bus.err_pulse <= 1'b0;
        end else begin
            bus.err_pulse <= s1_adv && s1_bad;
            if (s1_adv && !s1_bad) begin
                bus.out_valid <= s1_onehot;
                bus.out_data  <= result;
                bus.out_op    <= s1_op;
            end else if (drain) begin
                bus.out_valid <= '0;
            end
        end
    end

`ifdef DLP_CHAN_COUNT_EN
    logic [15:0] cnt [N_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) cnt[k] <= cnt[k] + 16'd1;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_cnt
        assign chan_count[k*16 +: 16] = cnt[k];
    end
`endif
endmodule

// File: tb/tb_demux_logic_pipe.sv
// Self-checking bench: directed and random traffic against a queue-based ordering/latency model.
// A second N_CH=3 instance exercises out-of-range channel handling.
module tb_demux_logic_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_logic_pipe_if #(.WIDTH(8), .N_CH(4)) bus ();
    demux_logic_pipe_if #(.WIDTH(8), .N_CH(3)) bus3 ();

`ifdef DLP_CHAN_COUNT_EN
    logic [63:0] chan_count4;
    logic [47:0] chan_count3;
    demux_logic_pipe #(.WIDTH(8), .N_CH(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave),  .chan_count(chan_count4));
    demux_logic_pipe #(.WIDTH(8), .N_CH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave), .chan_count(chan_count3));
`else
    demux_logic_pipe #(.WIDTH(8), .N_CH(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    demux_logic_pipe #(.WIDTH(8), .N_CH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
`endif

    typedef struct {
        logic [7:0] data;
        logic [1:0] op;
        int         ch;
        int         acc;
        int         vis;
    } item_t;

    item_t      q[$];
    logic [7:0] drained[$];
    int         cnt_model[4];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle from a negedge: drive, check against the model, clock, update the model.
    task automatic apply_stimulus(input logic v, input logic [7:0] ta, input logic [7:0] tb_b,
                                  input logic [1:0] top, input logic [1:0] tch,
                                  input logic [3:0] rdy, output logic acc);
        logic       vis;
        logic       drn;
        logic       exp_ready;
        logic [3:0] exp_valid;
        item_t      it;
        bus.in_valid  = v;
        bus.a         = ta;
        bus.b         = tb_b;
        bus.op        = top;
        bus.ch_sel    = tch;
        bus.out_ready = rdy;
        #1;
        vis       = (q.size() > 0) && (cyc >= q[0].vis);
        exp_valid = vis ? 4'(1 << q[0].ch) : 4'h0;
        check_output("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (vis) begin
            check_output("out_data", 32'(bus.out_data), 32'(q[0].data));
            check_output("out_op", 32'(bus.out_op), 32'(q[0].op));
        end
        drn       = vis && rdy[q[0].ch];
        exp_ready = (q.size() < 2) || drn;
        check_output("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check_output("err_pulse", 32'(bus.err_pulse), 32'h0);
        acc = v && exp_ready;
        @(posedge clk);
        cyc++;
        if (drn) begin
            drained.push_back(q[0].data);
            cnt_model[q[0].ch]++;
            void'(q.pop_front());
            if (q.size() > 0) q[0].vis = (q[0].acc + 1 > cyc) ? q[0].acc + 1 : cyc;
        end
        if (acc) begin
            it.data = ref_op(ta, tb_b, top);
            it.op   = top;
            it.ch   = int'(tch);
            it.acc  = cyc;
            it.vis  = cyc + 1;
            q.push_back(it);
        end
        @(negedge clk);
    endtask

    initial begin
        logic       acc;
        logic [7:0] ra, rb;
        logic [1:0] rop, rch;
        int         tries;
        logic [7:0] exp_ops[4];
        exp_ops[0] = 8'h88; exp_ops[1] = 8'hEE; exp_ops[2] = 8'h66; exp_ops[3] = 8'h11;
        for (int k = 0; k < 4; k++) cnt_model[k] = 0;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.ch_sel = '0; bus.out_ready = '0;
        bus3.in_valid = 1'b0; bus3.a = '0; bus3.b = '0; bus3.op = '0; bus3.ch_sel = '0; bus3.out_ready = '0;
        @(negedge clk);
        check_output("reset out_valid", 32'(bus.out_valid), 32'h0);
        check_output("reset out_data", 32'(bus.out_data), 32'h0);
        check_output("reset out_op", 32'(bus.out_op), 32'h0);
        check_output("reset err_pulse", 32'(bus.err_pulse), 32'h0);
        check_output("reset in_ready", 32'(bus.in_ready), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] ops");
        drained.delete();
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'hCC, 8'hAA, 2'(i), 2'd1, 4'hF, acc);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 4'hF, acc);
        check_output("ops count", 32'(drained.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < drained.size()) check_output("ops result", 32'(drained[i]), 32'(exp_ops[i]));
        end

        $display("[TB] streaming");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 2'(i % 4), 4'hF, acc);
            check_output("stream accept", 32'(acc), 32'h1);
        end
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 4'hF, acc);

        $display("[TB] backpressure");
        for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 8'(8'h10 + i), 8'h5A, 2'd2, 2'd2, 4'h0, acc);
        apply_stimulus(1'b1, 8'h12, 8'h5A, 2'd2, 2'd2, 4'h0, acc);
        check_output("bp blocked", 32'(acc), 32'h0);
        for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 8'h12, 8'h5A, 2'd2, 2'd2, 4'h1, acc);
        check_output("bp wrong ready", 32'(acc), 32'h0);
        tries = 0;
        do begin
            apply_stimulus(1'b1, 8'h12, 8'h5A, 2'd2, 2'd2, 4'h4, acc);
            tries++;
        end while (!acc && tries < 5);
        check_output("bp resume", 32'(acc), 32'h1);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 4'h4, acc);
        check_output("bp drained", 32'(q.size()), 32'h0);

        $display("[TB] random");
        for (int i = 0; i < 400; i++) begin
            ra  = 8'($urandom); rb = 8'($urandom);
            rop = 2'($urandom); rch = 2'($urandom);
            apply_stimulus(1'($urandom_range(0, 3) != 0), ra, rb, rop, rch, 4'($urandom), acc);
        end
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 4'hF, acc);
        check_output("random drained", 32'(q.size()), 32'h0);

`ifdef DLP_CHAN_COUNT_EN
        for (int k = 0; k < 4; k++)
            check_output("chan_count", 32'(chan_count4[k*16 +: 16]), 32'(cnt_model[k] & 16'hFFFF));
`endif

        $display("[TB] reset mid-op");
        for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 8'hF0, 8'h0F, 2'd1, 2'd3, 4'h0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst out_valid", 32'(bus.out_valid), 32'h0);
        check_output("midrst out_data", 32'(bus.out_data), 32'h0);
        check_output("midrst out_op", 32'(bus.out_op), 32'h0);
        check_output("midrst in_ready", 32'(bus.in_ready), 32'h0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 4'hF, acc);

        $display("[TB] bad channel");
        bus3.in_valid = 1'b1; bus3.ch_sel = 2'd3; bus3.a = 8'h55; bus3.b = 8'h55; bus3.op = 2'd0;
        bus3.out_ready = 3'b111;
        #1;
        check_output("bad in_ready", 32'(bus3.in_ready), 32'h1);
        @(posedge clk); @(negedge clk);
        check_output("bad err early", 32'(bus3.err_pulse), 32'h0);
        bus3.ch_sel = 2'd1; bus3.a = 8'hF0; bus3.b = 8'h3C; bus3.op = 2'd2;
        #1;
        check_output("bad next in_ready", 32'(bus3.in_ready), 32'h1);
        @(posedge clk); @(negedge clk);
        check_output("bad err pulse", 32'(bus3.err_pulse), 32'h1);
        check_output("bad no valid", 32'(bus3.out_valid), 32'h0);
        bus3.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check_output("bad err one cycle", 32'(bus3.err_pulse), 32'h0);
        check_output("after bad valid", 32'(bus3.out_valid), 32'h2);
        check_output("after bad data", 32'(bus3.out_data), 32'hCC);
        @(posedge clk); @(negedge clk);
        check_output("after bad drained", 32'(bus3.out_valid), 32'h0);

        bus3.out_ready = 3'b000;
        bus3.in_valid = 1'b1; bus3.ch_sel = 2'd0; bus3.a = 8'h0F; bus3.b = 8'hFF; bus3.op = 2'd0;
        @(posedge clk); @(negedge clk);
        bus3.ch_sel = 2'd3;
        @(posedge clk); @(negedge clk);
        bus3.in_valid = 1'b0;
        #1;
        check_output("bad skip in_ready", 32'(bus3.in_ready), 32'h1);
        check_output("bad skip held", 32'(bus3.out_valid), 32'h1);
        @(posedge clk); @(negedge clk);
        check_output("bad skip err", 32'(bus3.err_pulse), 32'h1);
        check_output("bad skip data", 32'(bus3.out_data), 32'h0F);
        check_output("bad skip valid", 32'(bus3.out_valid), 32'h1);
        bus3.out_ready = 3'b001;
        @(posedge clk); @(negedge clk);
        check_output("bad skip drain", 32'(bus3.out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
